// File: rtl/pipelined_cla_subtractor.sv
// Pipelined WIDTH-bit subtractor: diff = a - b - bin (mod 2^WIDTH), one 4-bit
// carry-lookahead nibble per stage. Computed as a + ~b + ~bin, so the carry out
// of the top nibble is the inverted borrow.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    operand handshake (a, b, bin)
//   out_valid / out_ready  result handshake (diff, bout, ovf, zero)
//   bout                   1 when unsigned a < b + bin
//   ovf                    signed overflow of the subtraction
//   zero                   diff == 0
//
// Latency is WIDTH/4 cycles. A full output stalls the whole pipe; bubbles are kept.
module pipelined_cla_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned STAGES = WIDTH / 4;
    // Number of intermediate stage registers (all stages except the output one).
    localparam int unsigned MID    = (STAGES > 1) ? STAGES - 1 : 1;

    // 4-bit lookahead adder: returns {carry_out, sum}.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Intermediate stage state. Operands carry the not-yet-consumed upper nibbles;
    // res carries the completed lower result nibbles.
    logic [MID-1:0]   valid_q;
    logic [MID-1:0]   carry_q;
    logic [WIDTH-1:0] a_q   [MID];
    logic [WIDTH-1:0] nb_q  [MID];
    logic [WIDTH-1:0] res_q [MID];

    // Output stage state.
    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    // Per-stage combinational view.
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_out;
    logic [WIDTH-1:0]  a_in   [STAGES];
    logic [WIDTH-1:0]  nb_in  [STAGES];
    logic [WIDTH-1:0]  res_nx [STAGES];
    logic              en;
    logic              a_msb;
    logic              b_msb;
    logic              ovf_d;

    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en;

    always_comb begin
        v_in  = '0;
        c_in  = '0;
        c_out = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            logic [4:0] r;
            logic [WIDTH-1:0] res_in;
            if (k == 0) begin
                v_in[k]  = in_valid;
                c_in[k]  = ~bin;
                a_in[k]  = a;
                nb_in[k] = ~b;
                res_in   = '0;
            end else begin
                v_in[k]  = valid_q[(k > 0) ? k - 1 : 0];
                c_in[k]  = carry_q[(k > 0) ? k - 1 : 0];
                a_in[k]  = a_q[(k > 0) ? k - 1 : 0];
                nb_in[k] = nb_q[(k > 0) ? k - 1 : 0];
                res_in   = res_q[(k > 0) ? k - 1 : 0];
            end
            r                  = cla4(a_in[k][4*k +: 4], nb_in[k][4*k +: 4], c_in[k]);
            c_out[k]           = r[4];
            res_nx[k]          = res_in;
            res_nx[k][4*k +: 4] = r[3:0];
        end
        a_msb = a_in[STAGES-1][WIDTH-1];
        b_msb = ~nb_in[STAGES-1][WIDTH-1];
        ovf_d = (a_msb != b_msb) && (res_nx[STAGES-1][WIDTH-1] != a_msb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            carry_q     <= '0;
            for (int k = 0; k < int'(MID); k++) begin
                a_q[k]   <= '0;
                nb_q[k]  <= '0;
                res_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < int'(STAGES) - 1; k++) begin
                valid_q[k] <= v_in[k];
                // Data only moves with a real beat so idle stages stay quiet.
                if (v_in[k]) begin
                    carry_q[k] <= c_out[k];
                    a_q[k]     <= a_in[k];
                    nb_q[k]    <= nb_in[k];
                    res_q[k]   <= res_nx[k];
                end
            end
            out_valid_q <= v_in[STAGES-1];
            if (v_in[STAGES-1]) begin
                diff_q <= res_nx[STAGES-1];
                bout_q <= ~c_out[STAGES-1];
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = (diff_q == '0);

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Directed and random bench for pipelined_cla_subtractor (WIDTH = 16).
module tb_pipelined_cla_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    int total = 0;
    int bad   = 0;

    pipelined_cla_subtractor #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One isolated beat with out_ready high: checks latency and all result flags.
    task automatic run_one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic vbin, input logic [15:0] ed, input logic eb,
                           input logic eo, input logic ez);
        @(negedge clk);
        a = va; b = vb; bin = vbin; in_valid = 1'b1;
        #1 check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat0"}, 32'(out_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check({tag, "_latn"}, 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_res"}, {13'd0, diff, bout, ovf, zero}, {13'd0, ed, eb, eo, ez});
    endtask

    logic [15:0] exp_stream [8] = '{16'hFEFF, 16'h1010, 16'h2121, 16'h3232,
                                    16'h4343, 16'h5454, 16'h6565, 16'h7676};

    initial begin
        int tx, rx, stall, cyc, highs, sent;
        logic first_seen;
        logic [15:0] held;
        logic [18:0] q [$];
        logic [18:0] e;
        logic [16:0] full;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_state", {26'd0, out_valid, diff == 16'h0, bout, ovf, zero, in_ready},
              {26'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        rst_n = 1'b1;

        // Fill the pipe, then reset mid-flight: every beat must vanish.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'h9000 + 16'(i); b = 16'h0001; bin = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("prefill_vld", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_state", {26'd0, out_valid, diff == 16'h0, bout, ovf, zero, in_ready},
              {26'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        highs = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) highs++;
        end
        check("no_stale", 32'(highs), 32'd0);

        // Directed vectors.
        run_one("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_one("wrap",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_one("binb",  16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_one("binz",  16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        run_one("ovfn",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_one("ovfp",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
        run_one("xnib",  16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);

        // Stream of 8 beats with a 3-cycle stall once the first result appears.
        tx = 0; rx = 0; stall = 0; cyc = 0; first_seen = 1'b0; held = '0;
        while (rx < 8 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (out_valid && !first_seen) begin
                first_seen = 1'b1; stall = 3; held = diff;
            end
            out_ready = (stall == 0);
            #1;
            if (stall > 0) begin
                check("stall_rdy", 32'(in_ready), 32'd0);
                check("stall_hold", {15'd0, out_valid, diff}, {15'd0, 1'b1, held});
                stall--;
            end else if (out_valid) begin
                check("stream_res", {14'd0, diff, bout, ovf},
                      {14'd0, exp_stream[rx], rx == 0, 1'b0});
                rx++;
            end else if (first_seen) begin
                check("stream_tput", 32'(out_valid), 32'd1);
            end
            in_valid = (tx < 8);
            a = 16'h1111 * 16'(tx); b = 16'h0101; bin = 1'b0;
            if (in_valid && in_ready) tx++;
        end
        check("stream_count", 32'(rx), 32'd8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(negedge clk);

        // Random soak against a plain arithmetic model.
        sent = 0; rx = 0; cyc = 0;
        while (rx < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("soak_extra", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("soak_res", {13'd0, diff, bout, ovf, zero}, {13'd0, e});
                end
                rx++;
            end
            in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            if (in_valid && in_ready) begin
                full = {1'b0, a} - {1'b0, b} - 17'(bin);
                e = {full[15:0], full[16],
                     (a[15] != b[15]) && (full[15] != a[15]), full[15:0] == 16'h0};
                q.push_back(e);
                sent++;
            end
        end
        check("soak_count", 32'(rx), 32'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_subtractor.md
# pipelined_cla_subtractor

Pipelined WIDTH-bit two's-complement subtractor with borrow-in, computing a − b − bin one 4-bit carry-lookahead nibble per pipeline stage. It is the arithmetic counterpart of the team's 4-bit carry-lookahead adder and reuses the same generate/propagate lookahead per nibble, operating on inverted b. It sits between an operand source and a result sink. Both sides use valid/ready handshakes, throughput is one operation per cycle, and latency is fixed.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 4; STAGES = WIDTH/4
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept an operand beat this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in (1 = subtract one extra)
- out_valid  output  1  result beat present
- out_ready  input  1  sink accepts result this cycle
- diff  output  WIDTH  a − b − bin, modulo 2^WIDTH
- bout  output  1  borrow-out: 1 when unsigned a < b + bin
- ovf  output  1  signed overflow of the subtraction
- zero  output  1  diff == 0

## Operation
- Subtraction is implemented as a + ~b + ~bin. Per nibble k: p = a ^ ~b, g = a & ~b, with a 4-bit lookahead carry chain; c_in(nibble 0) = ~bin.
- Stage k (k = 0..STAGES−1) computes nibble k from its delayed operands and the registered carry from stage k−1. Stage 0 computes combinationally from the ports and registers at acceptance.
- Operand skew: the unprocessed upper nibbles of a and ~b travel down the pipeline. Each stage drops the nibble it consumed.
- Result de-skew: completed lower result nibbles travel with the beat, so the last stage presents the full diff aligned.
- bout = ~carry out of the last nibble.
- ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]). Operand MSBs are carried to the last stage for this.
- zero is computed combinationally from the final registered diff.
- Each stage holds a valid bit. A beat is accepted on a rising edge when in_valid && in_ready.
- Global stall: en = !(out_valid && !out_ready).
  - in_ready = en.
  - All stage registers and valid bits advance only when en = 1.
  - Bubbles are not collapsed.
- The datapath needs no state machine. Pipeline occupancy is tracked solely by the per-stage valid bits.

## Timing
- Reset (rst_n low, asynchronous): all stage valid bits, diff, bout, ovf and carries clear to 0. zero reads 1 because diff = 0. in_ready reads 1 because out_valid = 0.
- Reset asserted mid-operation discards every in-flight beat immediately. The first beat accepted after rst_n deasserts is the first result produced.
- Latency: a beat accepted on edge t presents out_valid = 1 with its result in the cycle after edge t+STAGES−1 (4 cycles for WIDTH = 16), provided no stall occurs.
- Throughput: one beat per cycle while out_ready = 1.
- Outputs diff/bout/ovf/zero are stable and out_valid is held while out_valid && !out_ready. Nothing enters or moves.
- Same-cycle pop and push: when out_valid && out_ready && in_valid, the output beat retires, every stage advances and the new beat is accepted on the same edge.
- If in_valid is low when en = 1, a bubble (valid = 0) enters stage 0.
- The in_valid → in_ready path is not combinational. in_ready depends only on out_valid and out_ready.
- Results leave in acceptance order; no reordering.

## Test plan
- Reset and idle: assert rst_n = 0 with the pipeline full, then release it. Required: out_valid = 0, diff = 0x0000, bout = 0, ovf = 0, zero = 1, in_ready = 1. No stale result ever appears.
- Basic subtract with fixed latency (WIDTH = 16): a = 0x1234, b = 0x0234, bin = 0, accepted on edge t. Required: out_valid in the cycle after edge t+3, diff = 0x1000, bout = 0, ovf = 0, zero = 0.
- Borrow and wrap-around:
  - 0x0000 − 0x0001, bin = 0 → diff = 0xFFFF, bout = 1, ovf = 0.
  - 0x0005 − 0x0005, bin = 1 → diff = 0xFFFF, bout = 1.
  - 0x0005 − 0x0004, bin = 1 → diff = 0x0000, zero = 1, bout = 0.
- Signed overflow and cross-nibble carry:
  - 0x8000 − 0x0001 → diff = 0x7FFF, ovf = 1, bout = 0.
  - 0x7FFF − 0xFFFF → diff = 0x8000, ovf = 1, bout = 1.
  - 0x1000 − 0x0001 → diff = 0x0FFF (borrow crosses all stages).
- Back-to-back stream with backpressure: 8 consecutive beats (a = i·0x1111, b = 0x0101, bin = 0). Hold out_ready = 0 for 3 cycles after the first result appears. Required:
  - in_ready = 0 and outputs frozen throughout the stall.
  - No loss or duplication; results in order.
  - Throughput 1/cycle once out_ready = 1.
- Randomized gap/stall soak: 1000 random a/b/bin with random in_valid and out_ready. Compare against a reference model of a − b − bin: diff, bout, ovf and zero must match every retired beat.
